// File: rtl/wb_sram_fetch.sv
// Wishbone pipelined-mode read initiator: copies a block of 32-bit words from a bus
// address range into a local SRAM write port, keeping one request outstanding at a time.
module wb_sram_fetch #(
  parameter int MEM_AW    = 6,
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 3
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [31:0]       base_adr_i,
  input  logic [MEM_AW:0]   count_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [MEM_AW:0]   words_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic [31:0]       wb_adr_o,
  output logic              wb_we_o,
  output logic [3:0]        wb_sel_o,
  input  logic              wb_stall_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
  input  logic              wb_rty_i,
  input  logic [31:0]       wb_dat_i,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [31:0]       mem_data_o,
  output logic              mem_we_o
);

  localparam logic [MEM_AW:0] MAX_WORDS = {1'b1, {MEM_AW{1'b0}}};
  localparam logic [MEM_AW:0] ONE_WORD  = {{MEM_AW{1'b0}}, 1'b1};
  localparam logic [15:0]     TMO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [3:0]      RTY_MAX   = 4'(MAX_RETRY);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FINISH} state_t;

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [MEM_AW:0]     words_q, words_d;
  logic [MEM_AW:0]     remain_q, remain_d;
  logic                cyc_q, cyc_d;
  logic                stb_q, stb_d;
  logic [31:0]         adr_q, adr_d;
  logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_data_q, mem_data_d;
  logic                mem_we_q, mem_we_d;
  logic [3:0]          retry_q, retry_d;
  logic [15:0]         tmo_q, tmo_d;
  logic [MEM_AW:0]     count_c;

  assign count_c = (count_i > MAX_WORDS) ? MAX_WORDS : count_i;

  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    words_d    = words_q;
    remain_d   = remain_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    adr_d      = adr_q;
    mem_data_d = mem_data_q;
    mem_we_d   = 1'b0;
    retry_d    = retry_q;
    tmo_d      = tmo_q;
    // The write address advances the cycle after each write, so mem_addr_o is stable during mem_we_o.
    mem_addr_d = mem_we_q ? mem_addr_q + 1'b1 : mem_addr_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          busy_d     = 1'b1;
          err_d      = 1'b0;
          words_d    = '0;
          remain_d   = count_c;
          adr_d      = base_adr_i & 32'hFFFF_FFFC;
          mem_addr_d = '0;
          retry_d    = '0;
          tmo_d      = '0;
          if (count_c != '0) begin
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            state_d = S_REQ;
          end else begin
            state_d = S_FINISH;
          end
        end
      end

      S_REQ: begin
        if (!wb_stall_i) begin
          stb_d   = 1'b0;
          tmo_d   = '0;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (wb_err_i) begin
          err_d   = 1'b1;
          cyc_d   = 1'b0;
          state_d = S_FINISH;
        end else if (wb_ack_i) begin
          mem_we_d   = 1'b1;
          mem_data_d = wb_dat_i;
          words_d    = words_q + 1'b1;
          remain_d   = remain_q - 1'b1;
          adr_d      = adr_q + 32'd4;
          retry_d    = '0;
          if (remain_q == ONE_WORD) begin
            cyc_d   = 1'b0;
            state_d = S_FINISH;
          end else begin
            stb_d   = 1'b1;
            state_d = S_REQ;
          end
        end else if (wb_rty_i) begin
          if (retry_q < RTY_MAX) begin
            retry_d = retry_q + 4'd1;
            stb_d   = 1'b1;
            state_d = S_REQ;
          end else begin
            err_d   = 1'b1;
            cyc_d   = 1'b0;
            state_d = S_FINISH;
          end
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          cyc_d   = 1'b0;
          state_d = S_FINISH;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end

      S_FINISH: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      words_q    <= '0;
      remain_q   <= '0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      adr_q      <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q   <= 1'b0;
      retry_q    <= '0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      words_q    <= words_d;
      remain_q   <= remain_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      adr_q      <= adr_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_we_q   <= mem_we_d;
      retry_q    <= retry_d;
      tmo_q      <= tmo_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign words_o    = words_q;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = stb_q;
  assign wb_adr_o   = adr_q;
  assign wb_we_o    = 1'b0;
  assign wb_sel_o   = 4'hF;
  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;
  assign mem_we_o   = mem_we_q;

endmodule

// File: tb/tb_wb_sram_fetch.sv
// Directed bench for wb_sram_fetch: a scripted Wishbone responder driven cycle by cycle,
// with every outcome compared against hand-computed values.
module tb_wb_sram_fetch;
  localparam int AW = 6;

  logic          clk_i = 1'b0;
  logic          rst_n_i, start_i;
  logic [31:0]   base_adr_i;
  logic [AW:0]   count_i;
  logic          busy_o, done_o, err_o;
  logic [AW:0]   words_o;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0]   wb_adr_o;
  logic [3:0]    wb_sel_o;
  logic          wb_stall_i, wb_ack_i, wb_err_i, wb_rty_i;
  logic [31:0]   wb_dat_i;
  logic [AW-1:0] mem_addr_o;
  logic [31:0]   mem_data_o;
  logic          mem_we_o;

  always #5 clk_i = ~clk_i;

  wb_sram_fetch #(.MEM_AW(AW), .TIMEOUT(8), .MAX_RETRY(3)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .start_i(start_i), .base_adr_i(base_adr_i),
    .count_i(count_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .words_o(words_o),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_adr_o(wb_adr_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_stall_i(wb_stall_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_rty_i(wb_rty_i), .wb_dat_i(wb_dat_i), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_we_o(mem_we_o)
  );

  int n_chk = 0;
  int n_err = 0;
  int n_cyc, n_acc, n_wr, n_cycon, n_wait, n_stb, adr_bad;
  int stall_cfg, stall_left, poke_at, cur_resp;
  bit done_seen, pend, prev_stall;
  logic [31:0]   cur_dat, cur_base, prev_adr;
  logic [31:0]   acc_adr [128];
  logic [31:0]   wr_data [128];
  logic [AW-1:0] wr_addr [128];
  int plan[$];  // per accepted request: 0 ack, 1 err, 2 rty, 3 silent, 4 ack+err, 5 ack+rty

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_bus();
    wb_stall_i = 1'b0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_dat_i = '0;
  endtask

  // Observe DUT outputs for this cycle, then drive the responder inputs for the next edge.
  task automatic slave_step();
    if (mem_we_o && n_wr < 128) begin
      wr_addr[n_wr] = mem_addr_o; wr_data[n_wr] = mem_data_o; n_wr++;
    end
    if (done_o) done_seen = 1'b1;
    if (wb_cyc_o) n_cycon++;
    if (wb_cyc_o && !wb_stb_o) n_wait++;
    if (wb_stb_o) n_stb++;
    if (wb_stb_o && prev_stall && wb_adr_o !== prev_adr) adr_bad++;
    clear_bus();
    if (pend) begin
      pend = 1'b0;
      case (cur_resp)
        0: begin wb_ack_i = 1'b1; wb_dat_i = cur_dat; end
        1: wb_err_i = 1'b1;
        2: wb_rty_i = 1'b1;
        4: begin wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = cur_dat; end
        5: begin wb_ack_i = 1'b1; wb_rty_i = 1'b1; wb_dat_i = cur_dat; end
        default: ;
      endcase
    end
    prev_stall = 1'b0;
    if (wb_stb_o) begin
      if (stall_left > 0) begin
        wb_stall_i = 1'b1; stall_left--; prev_stall = 1'b1; prev_adr = wb_adr_o;
      end else begin
        if (n_acc < 128) acc_adr[n_acc] = wb_adr_o;
        n_acc++;
        pend = 1'b1;
        cur_resp = (plan.size() > 0) ? plan.pop_front() : 0;
        cur_dat = 32'hA0 + ((wb_adr_o - cur_base) >> 2);
        stall_left = stall_cfg;
      end
    end
  endtask

  task automatic run_xfer(input logic [31:0] base, input logic [AW:0] cnt, input int budget);
    @(negedge clk_i);
    base_adr_i = base; count_i = cnt; start_i = 1'b1;
    cur_base = base & 32'hFFFF_FFFC;
    n_cyc = 0; n_acc = 0; n_wr = 0; n_cycon = 0; n_wait = 0; n_stb = 0; adr_bad = 0;
    done_seen = 1'b0; pend = 1'b0; prev_stall = 1'b0; stall_left = stall_cfg;
    clear_bus();
    while (!done_seen && n_cyc < budget) begin
      @(negedge clk_i);
      n_cyc++;
      start_i = (n_cyc == poke_at);
      if (n_cyc == poke_at) begin base_adr_i = 32'hDEAD_0000; count_i = 7'd1; end
      slave_step();
    end
    start_i = 1'b0;
  endtask

  initial begin
    rst_n_i = 1'b0; start_i = 1'b0; base_adr_i = '0; count_i = '0;
    clear_bus();
    stall_cfg = 0; poke_at = -1; cur_resp = 0;
    repeat (3) @(negedge clk_i);
    chk("rst_ctrl", 64'({wb_cyc_o, wb_stb_o, busy_o, done_o, err_o, mem_we_o, wb_we_o}), 64'(0));
    chk("rst_adr", 64'(wb_adr_o), 64'(0));
    chk("rst_words_maddr", 64'({words_o, mem_addr_o}), 64'(0));
    chk("rst_mdata", 64'(mem_data_o), 64'(0));
    chk("rst_sel", 64'(wb_sel_o), 64'(4'hF));
    rst_n_i = 1'b1;

    // Zero-wait responder, four words.
    run_xfer(32'h100, 7'd4, 50);
    chk("t1_done", 64'(done_seen), 64'(1));
    chk("t1_latency", 64'(n_cyc), 64'(10));
    chk("t1_accepts", 64'(n_acc), 64'(4));
    chk("t1_writes", 64'(n_wr), 64'(4));
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_adr%0d", i), 64'(acc_adr[i]), 64'(32'h100 + 4 * i));
      chk($sformatf("t1_waddr%0d", i), 64'(wr_addr[i]), 64'(i));
      chk($sformatf("t1_wdata%0d", i), 64'(wr_data[i]), 64'(32'hA0 + i));
    end
    chk("t1_wait_cycles", 64'(n_wait), 64'(4));
    chk("t1_end", 64'({wb_cyc_o, busy_o, err_o}), 64'(0));
    chk("t1_words", 64'(words_o), 64'(4));
    @(negedge clk_i);
    chk("t1_done_pulse", 64'(done_o), 64'(0));

    // Three stall cycles on every request.
    stall_cfg = 3;
    run_xfer(32'h200, 7'd2, 50);
    stall_cfg = 0;
    chk("t2_latency", 64'(n_cyc), 64'(12));
    chk("t2_accepts", 64'(n_acc), 64'(2));
    chk("t2_stb_cycles", 64'(n_stb), 64'(8));
    chk("t2_adr_stable", 64'(adr_bad), 64'(0));
    chk("t2_adr1", 64'(acc_adr[1]), 64'(32'h204));
    chk("t2_wdata", 64'({wr_data[0], wr_data[1]}), 64'({32'hA0, 32'hA1}));
    chk("t2_words", 64'(words_o), 64'(2));

    // Bus error on the third word.
    plan = '{0, 0, 1};
    run_xfer(32'h300, 7'd4, 50);
    chk("t3_latency", 64'(n_cyc), 64'(8));
    chk("t3_writes", 64'(n_wr), 64'(2));
    chk("t3_words", 64'(words_o), 64'(2));
    chk("t3_err", 64'(err_o), 64'(1));
    chk("t3_cyc", 64'(wb_cyc_o), 64'(0));

    // Silent responder times out after 8 wait cycles.
    plan = '{3};
    run_xfer(32'h400, 7'd1, 50);
    chk("t4_latency", 64'(n_cyc), 64'(11));
    chk("t4_wait_cycles", 64'(n_wait), 64'(8));
    chk("t4_err_words", 64'({err_o, words_o}), 64'({1'b1, 7'd0}));
    chk("t4_writes", 64'(n_wr), 64'(0));

    // Three retries are tolerated, the fourth aborts.
    plan = '{2, 2, 2, 0};
    run_xfer(32'h500, 7'd1, 50);
    chk("t5a_accepts", 64'(n_acc), 64'(4));
    chk("t5a_same_adr", 64'(acc_adr[3]), 64'(32'h500));
    chk("t5a_writes", 64'(n_wr), 64'(1));
    chk("t5a_wdata", 64'(wr_data[0]), 64'(32'hA0));
    chk("t5a_err_words", 64'({err_o, words_o}), 64'({1'b0, 7'd1}));
    plan = '{2, 2, 2, 2};
    run_xfer(32'h500, 7'd1, 50);
    chk("t5b_accepts", 64'(n_acc), 64'(4));
    chk("t5b_writes", 64'(n_wr), 64'(0));
    chk("t5b_err_words", 64'({err_o, words_o}), 64'({1'b1, 7'd0}));

    // Simultaneous responses: ack beats rty, err beats ack.
    plan = '{5, 4};
    run_xfer(32'h580, 7'd2, 50);
    chk("t5c_accepts", 64'(n_acc), 64'(2));
    chk("t5c_writes", 64'(n_wr), 64'(1));
    chk("t5c_err_words", 64'({err_o, words_o}), 64'({1'b1, 7'd1}));

    // Zero-length transfer: no bus activity, error flag cleared by the start.
    run_xfer(32'h600, 7'd0, 20);
    chk("t6a_latency", 64'(n_cyc), 64'(2));
    chk("t6a_no_cyc", 64'(n_cycon), 64'(0));
    chk("t6a_err_words", 64'({err_o, words_o}), 64'(0));

    // Start pulse while busy is ignored.
    poke_at = 3;
    run_xfer(32'h700, 7'd3, 50);
    poke_at = -1;
    chk("t6b_accepts", 64'(n_acc), 64'(3));
    chk("t6b_adr2", 64'(acc_adr[2]), 64'(32'h708));
    chk("t6b_words", 64'(words_o), 64'(3));

    // Count above the SRAM size clamps to 64 words.
    run_xfer(32'h1000, 7'd100, 200);
    chk("t7_latency", 64'(n_cyc), 64'(130));
    chk("t7_words", 64'(words_o), 64'(64));
    chk("t7_writes", 64'(n_wr), 64'(64));
    chk("t7_last", 64'({wr_addr[63], wr_data[63]}), 64'({6'd63, 32'hDF}));

    // Low address bits ignored and 32-bit address wrap.
    run_xfer(32'hFFFF_FFFB, 7'd3, 50);
    chk("t8_adr0", 64'(acc_adr[0]), 64'(32'hFFFF_FFF8));
    chk("t8_adr2", 64'(acc_adr[2]), 64'(32'h0));
    chk("t8_wdata2", 64'(wr_data[2]), 64'(32'hA2));

    // Reset in the middle of a transfer.
    run_xfer(32'h800, 7'd4, 3);
    chk("t9_pre_cyc", 64'(wb_cyc_o), 64'(1));
    rst_n_i = 1'b0;
    #1;
    chk("t9_rst_ctrl", 64'({wb_cyc_o, wb_stb_o, busy_o, done_o, err_o, mem_we_o}), 64'(0));
    chk("t9_rst_adr_words", 64'({wb_adr_o, words_o}), 64'(0));
    clear_bus();
    pend = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    @(negedge clk_i);
    chk("t9_idle", 64'({wb_cyc_o, busy_o, mem_we_o}), 64'(0));
    run_xfer(32'h900, 7'd1, 20);
    chk("t9_after_latency", 64'(n_cyc), 64'(4));
    chk("t9_after_adr", 64'(acc_adr[0]), 64'(32'h900));
    chk("t9_after_words", 64'(words_o), 64'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
